div_8_bit_seq: RTL and testbench

//   Sequential restoring divider: unsigned WIDTH-bit dividend / divisor -> quotient, remainder.

---
 rtl/div_8_bit_seq.sv | 116 +++++++++++
 tb/tb_div_8_bit_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_8_bit_seq.sv
// rtl/div_8_bit_seq.sv - sequential restoring divider, one quotient bit per clock
module div_8_bit_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   state_t           state_next;

   // Partial remainder keeps one spare bit so the trial subtract never overflows.
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    cnt;

   logic [WIDTH+1:0] r_shift;
   logic [WIDTH+1:0] trial;
   logic             borrow;
   logic [WIDTH:0]   r_next;
   logic [WIDTH-1:0] q_next;
   logic             last;

   // One restoring step: shift {R,Q}, trial-subtract D, keep result when no borrow.
   always_comb begin
      r_shift = {r, q[WIDTH-1]};
      trial   = r_shift - {2'b00, d};
      borrow  = trial[WIDTH+1];
      r_next  = borrow ? r_shift[WIDTH:0] : trial[WIDTH:0];
      q_next  = {q[WIDTH-2:0], ~borrow};
      last    = (cnt == CW'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: divide-by-zero is answered straight from IDLE, never entering RUN.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start && (divisor != '0)) state_next = RUN;
         RUN:     if (last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore output.
   always_comb begin
      busy = (state == RUN);
   end

   // Datapath and registered results; done is a one-cycle flag set on completion edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     r   <= '0;
                     q   <= dividend;
                     d   <= divisor;
                     cnt <= '0;
                  end
               end
            end
            RUN: begin
               r   <= r_next;
               q   <= q_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  quotient    <= q_next;
                  remainder   <= r_next[WIDTH-1:0];
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_8_bit_seq.sv
// tb/tb_div_8_bit_seq.sv - self-checking bench for div_8_bit_seq
module tb_div_8_bit_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [W-1:0] n;
      logic [W-1:0] d;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } exp_t;

   exp_t sb[$];

   div_8_bit_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model pushed to the scoreboard when the operands are driven.
   task automatic push_exp(input logic [W-1:0] n, input logic [W-1:0] d);
      exp_t e;
      e.n = n;
      e.d = d;
      if (d == 0) begin
         e.q = '1;
         e.r = n;
         e.z = 1'b1;
      end else begin
         e.q = W'(int'(n) / int'(d));
         e.r = W'(int'(n) % int'(d));
         e.z = 1'b0;
      end
      sb.push_back(e);
   endtask

   // Called just after the accepting edge; waits (bounded) for done and scores it.
   // exp_lat < 0 skips latency/busy checks.
   task automatic finish_op(input int exp_lat);
      exp_t e;
      int   j;
      int   bcnt;
      bit   seen;
      j = 0;
      bcnt = 0;
      seen = 0;
      @(negedge clk);
      while (!seen && j < 20) begin
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if (busy === 1'b1) bcnt++;
            j++;
            @(negedge clk);
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (seen) begin
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
            chk("busy_at_done", 32'(busy), 32'd0);
            if (exp_lat >= 0) begin
               chk("latency", 32'(j), 32'(exp_lat));
               chk("busy_cycles", 32'(bcnt), 32'(exp_lat));
            end
            if (e.d != 0) begin
               chk("invariant", 32'(int'(quotient) * int'(e.d) + int'(remainder)), 32'(e.n));
               chk("rem_lt_div", 32'(remainder < e.d), 32'd1);
            end
         end
      end
   endtask

   // Drives a start at the current (negedge) point, so back-to-back calls start in the done cycle.
   task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d);
      dividend = n;
      divisor = d;
      start = 1'b1;
      push_exp(n, d);
      @(posedge clk);
      #1 start = 1'b0;
      finish_op((d == 0) ? 0 : W);
   endtask

   task automatic check_quiet(input string tag);
      @(negedge clk);
      chk(tag, 32'(done), 32'd0);
   endtask

   initial begin
      int dcount;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: basic division
      run_op(8'd200, 8'd7);
      check_quiet("t1_done_width");

      // 2: boundaries
      run_op(8'd255, 8'd1);
      check_quiet("t2a_done_width");
      run_op(8'd5, 8'd9);
      check_quiet("t2b_done_width");
      run_op(8'd0, 8'd3);
      check_quiet("t2c_done_width");
      run_op(8'd77, 8'd77);
      check_quiet("t2d_done_width");

      // 3: divide by zero, then a normal op
      run_op(8'd37, 8'd0);
      check_quiet("t3a_done_width");
      run_op(8'd37, 8'd5);
      check_quiet("t3b_done_width");

      // 4: start while busy is ignored
      dividend = 8'd100;
      divisor = 8'd3;
      start = 1'b1;
      push_exp(8'd100, 8'd3);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      dividend = 8'd9;
      divisor = 8'd9;
      @(posedge clk);
      #1 start = 1'b0;
      finish_op(-1);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("t4_single_done", 32'(dcount), 32'd0);

      // 5: asynchronous reset mid-division
      dividend = 8'd250;
      divisor = 8'd6;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_q", 32'(quotient), 32'd0);
      chk("t5_r", 32'(remainder), 32'd0);
      chk("t5_dbz", 32'(div_by_zero), 32'd0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
         if (i == 2) rst_n = 1'b1;
      end
      chk("t5_no_done", 32'(dcount), 32'd0);
      run_op(8'd250, 8'd6);
      check_quiet("t5_done_width");

      // 6: back-to-back random operands, divisor zero included
      for (int i = 0; i < 100; i++) begin
         logic [W-1:0] n;
         logic [W-1:0] d;
         n = W'($urandom_range(0, 255));
         d = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
         run_op(n, d);
      end

      // 6: sparse operand sweep, back-to-back
      for (int n = 0; n < 256; n += 15) begin
         for (int d = 0; d < 256; d += 7) begin
            run_op(W'(n), W'(d));
         end
         run_op(W'(n), 8'd255);
         run_op(W'(n), 8'd1);
      end
      check_quiet("sweep_end_done_width");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
